// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: aligns byte/half/word accesses onto a 32-bit req/ack bus,
// extends load data, and raises misalignment and bus-timeout exceptions.
module mem_lsu #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int PERIPH_BIT = 30,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_i,
  input  logic              st_i,
  input  logic [1:0]        size_i,
  input  logic              sign_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [3:0]        excode_o,
  output logic [ADDR_W-1:0] badvaddr_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic              bus_periph_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_sign;
  logic              r_req;
  logic              r_we;
  logic              r_periph;
  logic [3:0]        r_be;
  logic [DATA_W-1:0] r_wdata;

  logic              w_req;
  logic              w_misalign;
  logic              w_timeout;
  logic              w_rd_en;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_lane_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_ext;

  assign w_req      = ld_i | st_i;
  assign w_misalign = (size_i == 2'b01) ? addr_i[0] :
                      (size_i[1])       ? (addr_i[1:0] != 2'b00) : 1'b0;
  // Counter holds the number of ack-less BUSY cycles already elapsed.
  assign w_timeout  = (r_cnt == TO_LAST);

  always_comb begin
    w_be         = 4'b1111;
    w_lane_wdata = wdata_i;
    case (size_i)
      2'b00: begin
        w_be         = 4'b0001 << addr_i[1:0];
        w_lane_wdata = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        w_be         = addr_i[1] ? 4'b1100 : 4'b0011;
        w_lane_wdata = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    stall_o    = 1'b0;
    done_o     = 1'b0;
    excode_o   = 4'd0;
    badvaddr_o = '0;
    w_rd_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req && !flush_i) begin
          if (w_misalign) begin
            done_o     = 1'b1;
            excode_o   = st_i ? 4'd5 : 4'd4;
            badvaddr_o = addr_i;
          end else begin
            stall_o = 1'b1;
            w_next  = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        // An ack always beats a coincident timeout; a flush only suppresses reporting.
        if (bus_ack_i) begin
          w_next = S_IDLE;
          if (!flush_i) begin
            done_o  = 1'b1;
            w_rd_en = !r_we;
          end
        end else if (w_timeout) begin
          w_next = S_IDLE;
          if (!flush_i) begin
            done_o     = 1'b1;
            excode_o   = 4'd7;
            badvaddr_o = r_addr;
          end
        end else begin
          stall_o = 1'b1;
          if (flush_i) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        stall_o = 1'b1;
        if (bus_ack_i || w_timeout) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 8'd0;
      r_addr   <= '0;
      r_size   <= 2'b00;
      r_sign   <= 1'b0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_periph <= 1'b0;
      r_be     <= 4'b0000;
      r_wdata  <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= 8'd0;
      if (w_next == S_BUSY) begin
        r_addr   <= addr_i;
        r_size   <= size_i;
        r_sign   <= sign_i;
        r_req    <= 1'b1;
        r_we     <= st_i;
        r_periph <= addr_i[PERIPH_BIT];
        r_be     <= w_be;
        r_wdata  <= w_lane_wdata;
      end
    end else if (w_next == S_IDLE) begin
      r_req <= 1'b0;
      r_cnt <= 8'd0;
    end else if (!bus_ack_i) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = bus_rdata_i[7:0];
      2'd1:    w_byte = bus_rdata_i[15:8];
      2'd2:    w_byte = bus_rdata_i[23:16];
      default: w_byte = bus_rdata_i[31:24];
    endcase
    w_half = r_addr[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (r_size)
      2'b00:   w_ext = {{24{r_sign & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{r_sign & w_half[15]}}, w_half};
      default: w_ext = bus_rdata_i;
    endcase
  end

  assign rdata_o      = w_rd_en ? w_ext : '0;
  assign bus_req_o    = r_req;
  assign bus_we_o     = r_we;
  assign bus_periph_o = r_periph;
  assign bus_addr_o   = {r_addr[ADDR_W-1:2], 2'b00};
  assign bus_be_o     = r_be;
  assign bus_wdata_o  = r_wdata;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed vector table, hand-written multi-cycle corner sequences,
// and randomized accesses checked against an arithmetic reference model.
module tb_mem_lsu;

  logic        clk;
  logic        rst;
  logic        ld_i, st_i, sign_i, flush_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, done_o;
  logic [31:0] rdata_o;
  logic [3:0]  excode_o;
  logic [31:0] badvaddr_o;
  logic        bus_req_o, bus_we_o, bus_periph_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic [1:0]  dbg_state_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rword;
    int          lat;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_periph;
    logic [3:0]  exp_excode;
  } vec_t;

  vec_t tbl[10];

  mem_lsu #(.DATA_W(32), .ADDR_W(32), .PERIPH_BIT(30), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .ld_i(ld_i), .st_i(st_i), .size_i(size_i), .sign_i(sign_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .flush_i(flush_i), .stall_o(stall_o),
    .done_o(done_o), .rdata_o(rdata_o), .excode_o(excode_o), .badvaddr_o(badvaddr_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_periph_o(bus_periph_o),
    .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .dbg_state_o(dbg_state_o)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain arithmetic over the access rules
  function automatic logic model_misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    int off = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return (off >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg,
                                             input logic [31:0] a, input logic [31:0] w);
    int off = int'(a % 4);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (sg && v >= 128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (sg && v >= 32768) v = v - 32'd65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic vec_t mk(input logic ld, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rw, input int lat, input logic [31:0] er,
                              input logic [3:0] eb, input logic [31:0] ew,
                              input logic ep, input logic [3:0] ex);
    vec_t v;
    v.ld = ld; v.st = !ld; v.size = sz; v.sign = sg; v.addr = a; v.wdata = wd;
    v.rword = rw; v.lat = lat; v.exp_rdata = er; v.exp_be = eb; v.exp_wdata = ew;
    v.exp_periph = ep; v.exp_excode = ex;
    return v;
  endfunction

  // Driver: one complete access with the slave acking after v.lat ack-less BUSY cycles
  task automatic do_access(input vec_t v, input string nm);
    ld_i = v.ld; st_i = v.st; size_i = v.size; sign_i = v.sign;
    addr_i = v.addr; wdata_i = v.wdata; flush_i = 1'b0; bus_ack_i = 1'b0;
    @(negedge clk);
    if (v.exp_excode != 4'd0) begin
      chk({nm, " misal done"}, done_o, 1);
      chk({nm, " misal excode"}, excode_o, v.exp_excode);
      chk({nm, " misal badvaddr"}, badvaddr_o, v.addr);
      chk({nm, " misal stall"}, stall_o, 0);
      tick();
      ld_i = 1'b0; st_i = 1'b0;
      chk({nm, " misal no req"}, bus_req_o, 0);
      return;
    end
    chk({nm, " issue stall"}, stall_o, 1);
    chk({nm, " issue done"}, done_o, 0);
    if (v.ld) exp_q.push_back(v.exp_rdata);
    tick();
    ld_i = 1'b0; st_i = 1'b0;
    chk({nm, " req"}, bus_req_o, 1);
    chk({nm, " we"}, bus_we_o, v.st);
    chk({nm, " periph"}, bus_periph_o, v.exp_periph);
    chk({nm, " addr"}, bus_addr_o, v.addr & 32'hFFFF_FFFC);
    chk({nm, " be"}, bus_be_o, v.exp_be);
    if (v.st) chk({nm, " wdata"}, bus_wdata_o, v.exp_wdata);
    for (int k = 0; k < v.lat; k++) begin
      @(negedge clk);
      chk({nm, " busy stall"}, stall_o, 1);
      chk({nm, " busy done"}, done_o, 0);
      tick();
    end
    bus_ack_i = 1'b1;
    bus_rdata_i = v.rword;
    @(negedge clk);
    chk({nm, " ack done"}, done_o, 1);
    chk({nm, " ack stall"}, stall_o, 0);
    chk({nm, " ack excode"}, excode_o, 0);
    if (v.ld) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL %s scoreboard: got empty queue expected entry", nm);
      end else begin
        chk({nm, " rdata"}, rdata_o, exp_q.pop_front());
      end
    end
    tick();
    bus_ack_i = 1'b0;
    bus_rdata_i = $urandom;
    chk({nm, " req drop"}, bus_req_o, 0);
  endtask

  initial begin
    rst = 1'b1; ld_i = 0; st_i = 0; size_i = 0; sign_i = 0; addr_i = 0; wdata_i = 0;
    flush_i = 0; bus_ack_i = 0; bus_rdata_i = 0;

    tbl[0] = mk(1, 2'd2, 0, 32'h0000_0010, 0, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    tbl[1] = mk(1, 2'd0, 1, 32'h0000_0013, 0, 32'h8012_3456, 1, 32'hFFFF_FF80, 4'h8, 0, 0, 0);
    tbl[2] = mk(1, 2'd0, 0, 32'h0000_0013, 0, 32'h8012_3456, 0, 32'h0000_0080, 4'h8, 0, 0, 0);
    tbl[3] = mk(0, 2'd1, 0, 32'h4000_0006, 32'h1234, 0, 2, 0, 4'hC, 32'h1234_1234, 1, 0);
    tbl[4] = mk(1, 2'd1, 0, 32'h0000_0003, 0, 0, 0, 0, 4'h0, 0, 0, 4'd4);
    tbl[5] = mk(0, 2'd2, 0, 32'h0000_0002, 32'h55, 0, 0, 0, 4'h0, 0, 0, 4'd5);
    tbl[6] = mk(1, 2'd2, 0, 32'h0000_0020, 0, 32'hCAFE_F00D, 14, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
    tbl[7] = mk(1, 2'd1, 1, 32'h0000_0022, 0, 32'h8001_7FFF, 1, 32'hFFFF_8001, 4'hC, 0, 0, 0);
    tbl[8] = mk(0, 2'd0, 0, 32'h4000_0041, 32'h99AB, 0, 0, 0, 4'h2, 32'hABAB_ABAB, 1, 0);
    tbl[9] = mk(1, 2'd3, 0, 32'h0000_0008, 0, 32'h1357_9BDF, 2, 32'h1357_9BDF, 4'hF, 0, 0, 0);

    // Reset state
    @(negedge clk);
    chk("reset req", bus_req_o, 0);
    chk("reset be", bus_be_o, 0);
    chk("reset addr", bus_addr_o, 0);
    chk("reset wdata", bus_wdata_o, 0);
    chk("reset stall", stall_o, 0);
    chk("reset done", done_o, 0);
    chk("reset excode", excode_o, 0);
    tick();
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 10; i++) do_access(tbl[i], $sformatf("vec%0d", i));

    // Timeout: no ack for TIMEOUT BUSY cycles
    ld_i = 1; size_i = 2'd2; sign_i = 0; addr_i = 32'h4000_0100;
    tick();
    ld_i = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      chk("to stall", stall_o, 1);
      chk("to done early", done_o, 0);
      tick();
    end
    @(negedge clk);
    chk("to done", done_o, 1);
    chk("to excode", excode_o, 7);
    chk("to badvaddr", badvaddr_o, 32'h4000_0100);
    chk("to stall fall", stall_o, 0);
    tick();
    chk("to req drop", bus_req_o, 0);

    // flush in IDLE blocks the issue
    ld_i = 1; flush_i = 1; addr_i = 32'h0000_0030;
    @(negedge clk);
    chk("flush idle stall", stall_o, 0);
    chk("flush idle done", done_o, 0);
    tick();
    ld_i = 0; flush_i = 0;
    chk("flush idle no req", bus_req_o, 0);

    // flush in BUSY cycle 2, ack in cycle 5: DRAIN, never done
    ld_i = 1; addr_i = 32'h0000_0040;
    tick();
    ld_i = 0;
    @(negedge clk);
    chk("drain b1 stall", stall_o, 1);
    tick();
    flush_i = 1;
    @(negedge clk);
    chk("drain b2 stall", stall_o, 1);
    chk("drain b2 done", done_o, 0);
    tick();
    flush_i = 0;
    for (int k = 3; k <= 4; k++) begin
      @(negedge clk);
      chk("drain stall", stall_o, 1);
      chk("drain done", done_o, 0);
      chk("drain req", bus_req_o, 1);
      tick();
    end
    bus_ack_i = 1; bus_rdata_i = 32'h1111_2222;
    @(negedge clk);
    chk("drain ack done", done_o, 0);
    tick();
    bus_ack_i = 0;
    chk("drain req drop", bus_req_o, 0);
    @(negedge clk);
    chk("drain idle stall", stall_o, 0);

    // flush together with ack in BUSY: discarded
    ld_i = 1; addr_i = 32'h0000_0044;
    tick();
    ld_i = 0; flush_i = 1; bus_ack_i = 1;
    @(negedge clk);
    chk("flush+ack done", done_o, 0);
    chk("flush+ack stall", stall_o, 0);
    tick();
    flush_i = 0; bus_ack_i = 0;
    chk("flush+ack req drop", bus_req_o, 0);

    // Reset mid-BUSY clears the request immediately
    st_i = 1; size_i = 2'd2; addr_i = 32'h0000_0050; wdata_i = 32'h7;
    tick();
    st_i = 0;
    chk("rst pre req", bus_req_o, 1);
    #2;
    rst = 1;
    #1;
    chk("rst async req", bus_req_o, 0);
    chk("rst async stall", stall_o, 0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("rst after req", bus_req_o, 0);
    tick();

    // Randomized accesses against the reference model
    for (int i = 0; i < 60; i++) begin
      vec_t v;
      logic [1:0] sz;
      logic [31:0] a;
      logic is_ld;
      is_ld = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a = a & 32'hFFFF_FFFE;
        else if (sz[1]) a = a & 32'hFFFF_FFFC;
      end
      v.ld = is_ld; v.st = !is_ld; v.size = sz; v.sign = 1'($urandom_range(0, 1));
      v.addr = a; v.wdata = $urandom; v.rword = $urandom; v.lat = $urandom_range(0, 6);
      v.exp_rdata = model_load(sz, v.sign, a, v.rword);
      v.exp_be = model_be(sz, a);
      v.exp_wdata = model_wdata(sz, v.wdata);
      v.exp_periph = 1'((a >> 30) & 1);
      v.exp_excode = model_misaligned(sz, a) ? (is_ld ? 4'd4 : 4'd5) : 4'd0;
      do_access(v, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
